wb_stage: RTL and testbench
===========================

# wb_stage

Parametrised MIPS writeback stage that succeeds the fixed two-input writeback mux: it holds the MEM/WB pipeline register, selects among memory, ALU and link sources, and extracts and extends sub-word loads. It adds stall/flush control, misalignment detection, `$zero` write suppression and a retired-instruction counter. It sits between the MEM stage and the register file write port and also drives the WB forwarding path.

## Interface
- `DATA_WIDTH`, 32: datapath width; 32 or 64 only.
- `REG_ADDR_W`, 5: register-file address width.
- `CNT_W`, 32: retired-instruction counter width.
- `ZERO_SUPPRESS`, 1: when 1, a write to register 0 is never asserted.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `Stall` in 1: hold the WB register.
- `Flush` in 1: load a bubble into the WB register.
- `InValid` in 1: MEM-stage instruction is valid.
- `RegWriteIn` in 1: instruction writes a register.
- `WBSel` in 2: source select. 0=ALU, 1=memory, 2=link, 3=ALU.
- `LoadSize` in 2: load size. 0=byte, 1=half, 2=word, 3=full `DATA_WIDTH`.
- `LoadSigned` in 1: sign-extend (1) or zero-extend (0) sub-width loads.
- `WriteRegIn` in `REG_ADDR_W`: destination register.
- `ReadData` in `DATA_WIDTH`: aligned memory word.
- `ALUResult` in `DATA_WIDTH`: ALU result; low `OFF_W` = log2(`DATA_WIDTH`/8) bits give the byte offset for loads.
- `LinkAddr` in `DATA_WIDTH`: PC+8 for JAL/JALR.
- `WBValid` out 1: WB register holds a valid instruction.
- `RegWrite` out 1: register-file write enable.
- `WriteReg` out `REG_ADDR_W`: write address.
- `WriteData` out `DATA_WIDTH`: write data.
- `MisalignErr` out 1: registered load-misalignment flag.
- `RetireCount` out `CNT_W`: retired-instruction count.

## Operation
- Input-side combinational path (computed from current inputs):
  - Source: `WBSel`=0 or 3 → `ALUResult`; 2 → `LinkAddr`; 1 → extracted load.
  - Load extraction, offset `off` = `ALUResult[OFF_W-1:0]`:
    - byte: `ReadData[8*off +: 8]`
    - half: `ReadData[8*off +: 16]`
    - word: `ReadData[8*off +: 32]`
    - full: `ReadData`
    - Zero- or sign-extend to `DATA_WIDTH` per `LoadSigned`. Size 3 is treated as a full-width load.
    - Lane order is little-endian; `off`=0 selects bits [7:0].
  - Misaligned when `WBSel`=1 and any of:
    - half with `off[0]`=1
    - word with `off[1:0]`≠0
    - full with `off`≠0
    - With `DATA_WIDTH`=32 only the half and word rules can apply.
  - `RegWrite` is computed as `InValid & RegWriteIn & ~misaligned`, and additionally `& (WriteRegIn≠0)` when `ZERO_SUPPRESS`=1.
- The WB register captures `WBValid`, `RegWrite`, `WriteReg`, `WriteData` and `MisalignErr`.
- Update priority on each rising edge:
  1. Flush: `WBValid`, `RegWrite`, `MisalignErr` ← 0. `WriteReg` and `WriteData` ← 0.
  2. Else Stall: all fields hold.
  3. Else: all fields load from the input-side path, with `WBValid` ← `InValid`.
- `MisalignErr` is set only when `InValid`=1.
- `RetireCount` increments when `WBValid`=1 and (`Stall`=0 or `Flush`=1). The current occupant leaves WB in either case. It wraps modulo 2^`CNT_W`.

## Timing
- Reset (asynchronous, `rst_n`=0): every output is 0 immediately, including `RetireCount`. Reset has priority over `Flush` and `Stall`.
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- All outputs are driven directly from flops, with no combinational input-to-output path.
- While `Stall`=1 and `Flush`=0, outputs are stable. The register file may rewrite the same value each cycle; `RetireCount` does not change.
- `Flush` and `Stall` asserted together: flush wins.
- Counter wrap: at all-ones with a retire, the next value is 0.
- Deassertion of `rst_n` is synchronised externally. The first edge after release performs a normal update.

## Test plan
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 between edges while `WBValid`=1 and `RetireCount`=7.
  - Required: all outputs are 0 before the next edge.
- Signed byte load:
  - Stimulus: `ReadData`=0x80FF7F01, `ALUResult`=0x1002, `WBSel`=1, `LoadSize`=0, `LoadSigned`=1.
  - Required: `WriteData`=0xFFFFFFFF one cycle later.
  - With `LoadSigned`=0: `WriteData`=0x000000FF.
  - With `ALUResult`=0x1003: `WriteData`=0xFFFFFF80.
- Signed half load:
  - Stimulus: `ReadData`=0x80FF7F01, `ALUResult`=0x1002, `WBSel`=1, `LoadSize`=1, `LoadSigned`=1.
  - Required: `WriteData`=0xFFFF80FF.
- Misaligned half:
  - Stimulus: `LoadSize`=1, `ALUResult`=0x1001, `InValid`=1, `RegWriteIn`=1.
  - Required: `MisalignErr`=1, `RegWrite`=0, `WBValid`=1.
- Link and `$zero` write:
  - Stimulus 1: `WBSel`=2, `LinkAddr`=0x00400010, `WriteRegIn`=31.
  - Required: `RegWrite`=1, `WriteReg`=31, `WriteData`=0x00400010.
  - Stimulus 2: the same with `WriteRegIn`=0.
  - Required: `RegWrite`=0.
- Stall/flush with counter:
  - Stimulus:
    - Cycle 1: stream 3 valid instructions.
    - Cycle 2: `Stall`=1 for 2 cycles.
    - Cycle 4: `Stall`=1 and `Flush`=1 together.
  - Required:
    - Outputs hold during the stall.
    - `RetireCount` stays constant while stalled.
    - `RetireCount` increments by 1 on the flush edge.
    - After that edge, `WBValid`=0 and `RegWrite`=0.
  - Wrap check: preset the count to 2^`CNT_W`-1 by streaming (`CNT_W`=4). Required: the next retire gives 0.

Source files
------------

// File: rtl/wb_stage.sv
// MIPS writeback stage: MEM/WB pipeline register with source select,
// sub-word load extraction/extension, misalignment detection, $zero
// write suppression, stall/flush control and a retired-instruction counter.
module wb_stage #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned REG_ADDR_W    = 5,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned ZERO_SUPPRESS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  InValid,
    input  logic                  RegWriteIn,
    input  logic [1:0]            WBSel,
    input  logic [1:0]            LoadSize,
    input  logic                  LoadSigned,
    input  logic [REG_ADDR_W-1:0] WriteRegIn,
    input  logic [DATA_WIDTH-1:0] ReadData,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] LinkAddr,
    output logic                  WBValid,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteReg,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  MisalignErr,
    output logic [CNT_W-1:0]      RetireCount
);

    localparam int unsigned OFF_W = $clog2(DATA_WIDTH / 8);

    // Byte offset of the load within the aligned memory word.
    logic [OFF_W-1:0]      off;
    // Memory word shifted so the addressed byte lane sits at bit 0 (little-endian).
    logic [DATA_WIDTH-1:0] shiftedData;
    logic [DATA_WIDTH-1:0] loadData;
    logic                  misaligned;
    logic                  zeroOk;

    logic                  wbValidNext;
    logic                  regWriteNext;
    logic                  misalignNext;
    logic [DATA_WIDTH-1:0] writeDataNext;

    logic                  wbValidReg;
    logic                  regWriteReg;
    logic [REG_ADDR_W-1:0] writeRegReg;
    logic [DATA_WIDTH-1:0] writeDataReg;
    logic                  misalignReg;
    logic [CNT_W-1:0]      retireCountReg;

    assign off         = ALUResult[OFF_W-1:0];
    assign shiftedData = ReadData >> {off, 3'b000};

    // Extract the addressed sub-word and zero/sign-extend it to full width.
    always_comb begin
        loadData = ReadData;
        case (LoadSize)
            2'd0: loadData = LoadSigned ? DATA_WIDTH'($signed(shiftedData[7:0]))
                                        : DATA_WIDTH'(shiftedData[7:0]);
            2'd1: loadData = LoadSigned ? DATA_WIDTH'($signed(shiftedData[15:0]))
                                        : DATA_WIDTH'(shiftedData[15:0]);
            2'd2: loadData = LoadSigned ? DATA_WIDTH'($signed(shiftedData[31:0]))
                                        : DATA_WIDTH'(shiftedData[31:0]);
            default: loadData = ReadData;
        endcase
    end

    // Flag loads whose offset is not a multiple of the access size.
    // At 32-bit width a full load is a word load, so both rules coincide.
    always_comb begin
        misaligned = 1'b0;
        if (WBSel == 2'd1) begin
            case (LoadSize)
                2'd1:    misaligned = off[0];
                2'd2:    misaligned = (off[1:0] != 2'b00);
                2'd3:    misaligned = (off != '0);
                default: misaligned = 1'b0;
            endcase
        end
    end

    // Select the writeback source and form the next register contents.
    always_comb begin
        case (WBSel)
            2'd1:    writeDataNext = loadData;
            2'd2:    writeDataNext = LinkAddr;
            default: writeDataNext = ALUResult;
        endcase
        zeroOk       = (ZERO_SUPPRESS == 0) || (WriteRegIn != '0);
        wbValidNext  = InValid;
        regWriteNext = InValid & RegWriteIn & ~misaligned & zeroOk;
        misalignNext = InValid & misaligned;
    end

    // MEM/WB register: flush beats stall, stall holds, otherwise load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbValidReg   <= 1'b0;
            regWriteReg  <= 1'b0;
            writeRegReg  <= '0;
            writeDataReg <= '0;
            misalignReg  <= 1'b0;
        end else if (Flush) begin
            wbValidReg   <= 1'b0;
            regWriteReg  <= 1'b0;
            writeRegReg  <= '0;
            writeDataReg <= '0;
            misalignReg  <= 1'b0;
        end else if (!Stall) begin
            wbValidReg   <= wbValidNext;
            regWriteReg  <= regWriteNext;
            writeRegReg  <= WriteRegIn;
            writeDataReg <= writeDataNext;
            misalignReg  <= misalignNext;
        end
    end

    // Count an instruction whenever a valid occupant leaves WB (advance or flush).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retireCountReg <= '0;
        end else if (wbValidReg && (!Stall || Flush)) begin
            retireCountReg <= retireCountReg + 1'b1;
        end
    end

    assign WBValid     = wbValidReg;
    assign RegWrite    = regWriteReg;
    assign WriteReg    = writeRegReg;
    assign WriteData   = writeDataReg;
    assign MisalignErr = misalignReg;
    assign RetireCount = retireCountReg;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table for the datapath plus
// hand-written reset, stall/flush and counter-wrap sequences.
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        Stall;
    logic        Flush;
    logic        InValid;
    logic        RegWriteIn;
    logic [1:0]  WBSel;
    logic [1:0]  LoadSize;
    logic        LoadSigned;
    logic [4:0]  WriteRegIn;
    logic [31:0] ReadData;
    logic [31:0] ALUResult;
    logic [31:0] LinkAddr;
    logic        WBValid;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        MisalignErr;
    logic [3:0]  RetireCount;

    int checks = 0;
    int errors = 0;

    wb_stage #(
        .DATA_WIDTH   (32),
        .REG_ADDR_W   (5),
        .CNT_W        (4),
        .ZERO_SUPPRESS(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Stall      (Stall),
        .Flush      (Flush),
        .InValid    (InValid),
        .RegWriteIn (RegWriteIn),
        .WBSel      (WBSel),
        .LoadSize   (LoadSize),
        .LoadSigned (LoadSigned),
        .WriteRegIn (WriteRegIn),
        .ReadData   (ReadData),
        .ALUResult  (ALUResult),
        .LinkAddr   (LinkAddr),
        .WBValid    (WBValid),
        .RegWrite   (RegWrite),
        .WriteReg   (WriteReg),
        .WriteData  (WriteData),
        .MisalignErr(MisalignErr),
        .RetireCount(RetireCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        inValid;
        logic        regWriteIn;
        logic [1:0]  wbSel;
        logic [1:0]  loadSize;
        logic        loadSigned;
        logic [4:0]  wr;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [31:0] link;
        logic        expValid;
        logic        expRw;
        logic [4:0]  expWr;
        logic [31:0] expWd;
        logic        expMis;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, ".WBValid"}, 32'(WBValid), 32'd0);
        check({tag, ".RegWrite"}, 32'(RegWrite), 32'd0);
        check({tag, ".WriteReg"}, 32'(WriteReg), 32'd0);
        check({tag, ".WriteData"}, WriteData, 32'd0);
        check({tag, ".MisalignErr"}, 32'(MisalignErr), 32'd0);
        check({tag, ".RetireCount"}, 32'(RetireCount), 32'd0);
    endtask

    task automatic setInstr(input logic v, input logic [4:0] wr, input logic [31:0] alu);
        InValid    = v;
        RegWriteIn = 1'b1;
        WBSel      = 2'd0;
        LoadSize   = 2'd2;
        LoadSigned = 1'b0;
        WriteRegIn = wr;
        ReadData   = 32'h0;
        ALUResult  = alu;
        LinkAddr   = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        Stall = 1'b0;
        Flush = 1'b0;
        setInstr(1'b0, 5'd0, 32'h0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        // {inValid, rwIn, sel, size, signed, wr, rd, alu, link, expValid, expRw, expWr, expWd, expMis}
        vecs[0]  = '{1, 1, 2'd1, 2'd0, 1, 5'd5,  32'h80FF7F01, 32'h00001002, 32'h0, 1, 1, 5'd5,  32'hFFFFFFFF, 0};
        vecs[1]  = '{1, 1, 2'd1, 2'd0, 0, 5'd5,  32'h80FF7F01, 32'h00001002, 32'h0, 1, 1, 5'd5,  32'h000000FF, 0};
        vecs[2]  = '{1, 1, 2'd1, 2'd0, 1, 5'd6,  32'h80FF7F01, 32'h00001003, 32'h0, 1, 1, 5'd6,  32'hFFFFFF80, 0};
        vecs[3]  = '{1, 1, 2'd1, 2'd1, 1, 5'd6,  32'h80FF7F01, 32'h00001002, 32'h0, 1, 1, 5'd6,  32'hFFFF80FF, 0};
        vecs[4]  = '{1, 1, 2'd1, 2'd1, 0, 5'd7,  32'h80FF7F01, 32'h00001001, 32'h0, 1, 0, 5'd7,  32'h0000FF7F, 1};
        vecs[5]  = '{1, 1, 2'd2, 2'd0, 0, 5'd31, 32'h0,        32'h00000004, 32'h00400010, 1, 1, 5'd31, 32'h00400010, 0};
        vecs[6]  = '{1, 1, 2'd2, 2'd0, 0, 5'd0,  32'h0,        32'h00000004, 32'h00400010, 1, 0, 5'd0,  32'h00400010, 0};
        vecs[7]  = '{1, 1, 2'd0, 2'd1, 1, 5'd7,  32'h0,        32'h12345678, 32'h0, 1, 1, 5'd7,  32'h12345678, 0};
        vecs[8]  = '{1, 1, 2'd3, 2'd0, 0, 5'd8,  32'h0,        32'hDEADBEEF, 32'h0, 1, 1, 5'd8,  32'hDEADBEEF, 0};
        vecs[9]  = '{1, 1, 2'd1, 2'd2, 0, 5'd10, 32'hCAFEBABE, 32'h00002000, 32'h0, 1, 1, 5'd10, 32'hCAFEBABE, 0};
        vecs[10] = '{1, 1, 2'd1, 2'd2, 1, 5'd11, 32'hCAFEBABE, 32'h00002002, 32'h0, 1, 0, 5'd11, 32'h0000CAFE, 1};
        vecs[11] = '{0, 1, 2'd1, 2'd1, 0, 5'd9,  32'h80FF7F01, 32'h00001001, 32'h0, 0, 0, 5'd9,  32'h0000FF7F, 0};
        vecs[12] = '{1, 1, 2'd1, 2'd3, 1, 5'd12, 32'h87654321, 32'h00003000, 32'h0, 1, 1, 5'd12, 32'h87654321, 0};
        vecs[13] = '{1, 1, 2'd1, 2'd1, 1, 5'd13, 32'h1234F00D, 32'h00003000, 32'h0, 1, 1, 5'd13, 32'hFFFFF00D, 0};
        vecs[14] = '{1, 0, 2'd1, 2'd0, 0, 5'd14, 32'h80FF7F01, 32'h00003001, 32'h0, 1, 0, 5'd14, 32'h0000007F, 0};

        // Power-up reset: outputs must be zero before any clock edge.
        rst_n = 1'b0;
        Stall = 1'b0;
        Flush = 1'b0;
        setInstr(1'b0, 5'd0, 32'h0);
        #1;
        checkAllZero("reset");
        $display("txn reset: outputs checked at power-up");
        step();
        rst_n = 1'b1;

        // Datapath vectors, one instruction per cycle.
        for (int i = 0; i < NVEC; i++) begin
            InValid    = vecs[i].inValid;
            RegWriteIn = vecs[i].regWriteIn;
            WBSel      = vecs[i].wbSel;
            LoadSize   = vecs[i].loadSize;
            LoadSigned = vecs[i].loadSigned;
            WriteRegIn = vecs[i].wr;
            ReadData   = vecs[i].rd;
            ALUResult  = vecs[i].alu;
            LinkAddr   = vecs[i].link;
            step();
            $display("txn vec%0d: valid=%0b rw=%0b wr=%0d wd=0x%08h mis=%0b",
                     i, WBValid, RegWrite, WriteReg, WriteData, MisalignErr);
            check($sformatf("vec%0d.WBValid", i), 32'(WBValid), 32'(vecs[i].expValid));
            check($sformatf("vec%0d.RegWrite", i), 32'(RegWrite), 32'(vecs[i].expRw));
            check($sformatf("vec%0d.WriteReg", i), 32'(WriteReg), 32'(vecs[i].expWr));
            check($sformatf("vec%0d.WriteData", i), WriteData, vecs[i].expWd);
            check($sformatf("vec%0d.MisalignErr", i), 32'(MisalignErr), 32'(vecs[i].expMis));
        end

        // Reset mid-operation: build up count 7 with a valid occupant, then reset between edges.
        doReset();
        for (int i = 0; i < 8; i++) begin
            setInstr(1'b1, 5'd2, 32'(i));
            step();
        end
        check("midrst.pre.RetireCount", 32'(RetireCount), 32'd7);
        check("midrst.pre.WBValid", 32'(WBValid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkAllZero("midrst");
        $display("txn midrst: async reset between edges");
        step();
        rst_n = 1'b1;

        // Stall/flush: stream A, B, C; stall twice; then stall+flush together.
        setInstr(1'b0, 5'd0, 32'h0);
        setInstr(1'b1, 5'd1, 32'h111); step();
        setInstr(1'b1, 5'd2, 32'h222); step();
        setInstr(1'b1, 5'd3, 32'h333); step();
        check("stream.RetireCount", 32'(RetireCount), 32'd2);
        setInstr(1'b1, 5'd4, 32'h444);
        Stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            $display("txn stall%0d: valid=%0b wr=%0d wd=0x%08h cnt=%0d",
                     i, WBValid, WriteReg, WriteData, RetireCount);
            check($sformatf("stall%0d.WBValid", i), 32'(WBValid), 32'd1);
            check($sformatf("stall%0d.RegWrite", i), 32'(RegWrite), 32'd1);
            check($sformatf("stall%0d.WriteReg", i), 32'(WriteReg), 32'd3);
            check($sformatf("stall%0d.WriteData", i), WriteData, 32'h333);
            check($sformatf("stall%0d.RetireCount", i), 32'(RetireCount), 32'd2);
        end
        Flush = 1'b1;
        step();
        $display("txn flush: valid=%0b rw=%0b cnt=%0d", WBValid, RegWrite, RetireCount);
        check("flush.RetireCount", 32'(RetireCount), 32'd3);
        check("flush.WBValid", 32'(WBValid), 32'd0);
        check("flush.RegWrite", 32'(RegWrite), 32'd0);
        check("flush.WriteData", WriteData, 32'd0);
        check("flush.WriteReg", 32'(WriteReg), 32'd0);
        Stall = 1'b0;
        Flush = 1'b0;

        // Counter wrap: 16 edges of valid stream -> first loads, next 15 retire -> count 15.
        doReset();
        for (int i = 0; i < 16; i++) begin
            setInstr(1'b1, 5'd4, 32'(i));
            step();
        end
        check("wrap.pre.RetireCount", 32'(RetireCount), 32'd15);
        step();
        $display("txn wrap: cnt=%0d", RetireCount);
        check("wrap.RetireCount", 32'(RetireCount), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
